// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour type for the graphic controller.
// The sprite controller imports rgb24_t from here as well.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel coordinate / colour exchange and DAC pins of the VGA output stage.
// master = timing generator, slave = sprite controller + DAC side.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic        vga_clock;
  logic        SYNC_N_o;
  logic        v_en_o;
  logic [7:0]  R_o;
  logic [7:0]  G_o;
  logic [7:0]  B_o;
  logic        H_SYNC_o;
  logic        V_SYNC_o;
  logic [31:0] x_pos_o;
  logic [31:0] y_pos_o;
  rgb24_t      RGB_i;

  modport master (
    output vga_clock, SYNC_N_o, v_en_o, R_o, G_o, B_o, H_SYNC_o, V_SYNC_o, x_pos_o, y_pos_o,
    input  RGB_i
  );

  modport slave (
    input  vga_clock, SYNC_N_o, v_en_o, R_o, G_o, B_o, H_SYNC_o, V_SYNC_o, x_pos_o, y_pos_o,
    output RGB_i
  );

endinterface

// File: rtl/vga_counter.sv
// Wrap counter with enable: counts 0..max_i, carry_o flags the wrapping increment.
module vga_counter #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] cnt_o,
  output logic             carry_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign carry_o = en_i && (cnt_q == max_i);
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = carry_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: clk/2 pixel clock, raster counters, and a one-pixel
// output stage aligning colour, syncs and blank to the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned HVisible = H_VISIBLE,
  parameter int unsigned HFront   = H_FRONT,
  parameter int unsigned HSync    = H_SYNC,
  parameter int unsigned HBack    = H_BACK,
  parameter int unsigned VVisible = V_VISIBLE,
  parameter int unsigned VFront   = V_FRONT,
  parameter int unsigned VSync    = V_SYNC,
  parameter int unsigned VBack    = V_BACK
) (
  input logic               clk,
  input logic               rst,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned HTotal     = HVisible + HFront + HSync + HBack;
  localparam int unsigned VTotal     = VVisible + VFront + VSync + VBack;
  localparam int unsigned HSyncStart = HVisible + HFront;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync;
  localparam int unsigned VSyncStart = VVisible + VFront;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync;
  localparam int unsigned HW         = $clog2(HTotal);
  localparam int unsigned VW         = $clog2(VTotal);

  logic          vga_clock_q;
  logic          pix_tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_carry;
  logic          unused_v_carry;
  logic [31:0]   x_pos, y_pos;
  logic          visible, hs_act, vs_act;
  rgb24_t        rgb;
  logic          hs_q, vs_q, ven_q;
  logic [7:0]    r_q, g_q, b_q;

  // Pixel state moves on the edge where vga_clock falls, so it is stable at its rise.
  assign pix_tick = vga_clock_q;

  vga_counter #(
    .Width (HW)
  ) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (pix_tick),
    .max_i   (HW'(HTotal - 1)),
    .cnt_o   (h_cnt),
    .carry_o (h_carry)
  );

  vga_counter #(
    .Width (VW)
  ) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (h_carry),
    .max_i   (VW'(VTotal - 1)),
    .cnt_o   (v_cnt),
    .carry_o (unused_v_carry)
  );

  assign x_pos   = 32'(h_cnt);
  assign y_pos   = 32'(v_cnt);
  assign visible = (x_pos < HVisible) && (y_pos < VVisible);
  assign hs_act  = (x_pos >= HSyncStart) && (x_pos < HSyncEnd);
  assign vs_act  = (y_pos >= VSyncStart) && (y_pos < VSyncEnd);
  assign rgb     = vga.RGB_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_clock_q <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      ven_q       <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      vga_clock_q <= ~vga_clock_q;
      if (pix_tick) begin
        hs_q  <= ~hs_act;
        vs_q  <= ~vs_act;
        ven_q <= visible;
        r_q   <= visible ? rgb.r : 8'h00;
        g_q   <= visible ? rgb.g : 8'h00;
        b_q   <= visible ? rgb.b : 8'h00;
      end
    end
  end

  assign vga.vga_clock = vga_clock_q;
  assign vga.SYNC_N_o  = 1'b0;
  assign vga.v_en_o    = ven_q;
  assign vga.R_o       = r_q;
  assign vga.G_o       = g_q;
  assign vga.B_o       = b_q;
  assign vga.H_SYNC_o  = hs_q;
  assign vga.V_SYNC_o  = vs_q;
  assign vga.x_pos_o   = x_pos;
  assign vga.y_pos_o   = y_pos;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full 640x480 instance for line timing and latency, and a
// shrunken-timing instance for whole-frame wrap, vsync and mid-frame reset.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int unsigned SHV = 8;
  localparam int unsigned SHF = 2;
  localparam int unsigned SHS = 3;
  localparam int unsigned SHB = 2;
  localparam int unsigned SVV = 4;
  localparam int unsigned SVF = 1;
  localparam int unsigned SVS = 2;
  localparam int unsigned SVB = 1;

  typedef struct {
    logic        vclk;
    logic [31:0] x;
    logic [31:0] y;
    logic        hs;
    logic        vs;
    logic        ven;
    logic        sn;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_f, rst_s;
  logic        loop_f, loop_s;
  logic [23:0] rgb_f, rgb_s;
  int          checks = 0;
  int          failures = 0;

  vga_timing_gen_if bus_f ();
  vga_timing_gen_if bus_s ();

  always #5 clk = ~clk;

  // Loopback mode feeds the published coordinate back as colour.
  always_comb begin
    bus_f.RGB_i = loop_f ? rgb24_t'({8'h00, bus_f.x_pos_o[7:0], bus_f.y_pos_o[7:0]})
                         : rgb24_t'(rgb_f);
    bus_s.RGB_i = loop_s ? rgb24_t'({8'h00, bus_s.x_pos_o[7:0], bus_s.y_pos_o[7:0]})
                         : rgb24_t'(rgb_s);
  end

  vga_timing_gen u_dut_f (
    .clk (clk),
    .rst (rst_f),
    .vga (bus_f)
  );

  vga_timing_gen #(
    .HVisible (SHV),
    .HFront   (SHF),
    .HSync    (SHS),
    .HBack    (SHB),
    .VVisible (SVV),
    .VFront   (SVF),
    .VSync    (SVS),
    .VBack    (SVB)
  ) u_dut_s (
    .clk (clk),
    .rst (rst_s),
    .vga (bus_s)
  );

  function automatic obs_t sample(bit full);
    obs_t o;
    if (full) begin
      o.vclk = bus_f.vga_clock; o.x = bus_f.x_pos_o; o.y = bus_f.y_pos_o;
      o.hs = bus_f.H_SYNC_o; o.vs = bus_f.V_SYNC_o; o.ven = bus_f.v_en_o;
      o.sn = bus_f.SYNC_N_o; o.r = bus_f.R_o; o.g = bus_f.G_o; o.b = bus_f.B_o;
    end else begin
      o.vclk = bus_s.vga_clock; o.x = bus_s.x_pos_o; o.y = bus_s.y_pos_o;
      o.hs = bus_s.H_SYNC_o; o.vs = bus_s.V_SYNC_o; o.ven = bus_s.v_en_o;
      o.sn = bus_s.SYNC_N_o; o.r = bus_s.R_o; o.g = bus_s.G_o; o.b = bus_s.B_o;
    end
    return o;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(bit full, string tag);
    obs_t o;
    o = sample(full);
    check({tag, "_vclk"}, 32'(o.vclk), 32'd0);
    check({tag, "_x"}, o.x, 32'd0);
    check({tag, "_y"}, o.y, 32'd0);
    check({tag, "_hs"}, 32'(o.hs), 32'd1);
    check({tag, "_vs"}, 32'(o.vs), 32'd1);
    check({tag, "_ven"}, 32'(o.ven), 32'd0);
    check({tag, "_rgb"}, {8'h00, o.r, o.g, o.b}, 32'd0);
    check({tag, "_sync_n"}, 32'(o.sn), 32'd0);
  endtask

  // Steps n pixel ticks from counter (0,0) and compares against the raster model.
  task automatic run(bit full, int n, bit loop, logic [23:0] rgb);
    int unsigned ht, vt, hv, vv, hss, hse, vss, vse;
    int unsigned hp, vp, hn, vn;
    int          ven_line, hs_line, vs_frame;
    logic        ven_e;
    logic [23:0] exp_rgb;
    obs_t        o;
    ht  = full ? H_TOTAL : SHV + SHF + SHS + SHB;
    vt  = full ? V_TOTAL : SVV + SVF + SVS + SVB;
    hv  = full ? H_VISIBLE : SHV;
    vv  = full ? V_VISIBLE : SVV;
    hss = full ? H_VISIBLE + H_FRONT : SHV + SHF;
    hse = full ? H_VISIBLE + H_FRONT + H_SYNC : SHV + SHF + SHS;
    vss = full ? V_VISIBLE + V_FRONT : SVV + SVF;
    vse = full ? V_VISIBLE + V_FRONT + V_SYNC : SVV + SVF + SVS;
    ven_line = 0;
    hs_line  = 0;
    vs_frame = 0;
    for (int t = 1; t <= n; t++) begin
      hp = (t - 1) % ht;
      vp = ((t - 1) / ht) % vt;
      hn = t % ht;
      vn = (t / ht) % vt;
      @(negedge clk);
      o = sample(full);
      check("vclk_high", 32'(o.vclk), 32'd1);
      check("x_hold", o.x, hp);
      @(negedge clk);
      o = sample(full);
      ven_e   = (hp < hv) && (vp < vv);
      exp_rgb = !ven_e ? 24'h0 : loop ? {8'h00, hp[7:0], vp[7:0]} : rgb;
      check("vclk_low", 32'(o.vclk), 32'd0);
      check("x_pos", o.x, hn);
      check("y_pos", o.y, vn);
      check("h_sync", 32'(o.hs), 32'(!((hp >= hss) && (hp < hse))));
      check("v_sync", 32'(o.vs), 32'(!((vp >= vss) && (vp < vse))));
      check("v_en", 32'(o.ven), 32'(ven_e));
      check("rgb", {8'h00, o.r, o.g, o.b}, {8'h00, exp_rgb});
      check("sync_n", 32'(o.sn), 32'd0);
      if (t <= int'(ht)) begin
        ven_line += int'(o.ven);
        hs_line  += int'(!o.hs);
      end
      if (t <= int'(ht * vt)) vs_frame += int'(!o.vs);
    end
    if (n >= int'(ht)) begin
      check("ven_per_line", ven_line, hv);
      check("hs_low_per_line", hs_line, hse - hss);
    end
    if (n >= int'(ht * vt)) check("vs_low_per_frame", vs_frame, (vse - vss) * ht);
  endtask

  initial begin
    obs_t o;
    rst_f  = 1'b1;
    rst_s  = 1'b1;
    loop_f = 1'b0;
    loop_s = 1'b0;
    rgb_f  = 24'hFF8040;
    rgb_s  = 24'hFF8040;
    repeat (3) @(negedge clk);
    check_reset(1'b0, "rst_s_a");
    check_reset(1'b1, "rst_f_a");
    @(negedge clk);
    check_reset(1'b0, "rst_s_b");
    check_reset(1'b1, "rst_f_b");

    // Shrunken timing: two frames of constant colour, then loopback.
    rst_s = 1'b0;
    run(1'b0, 240, 1'b0, 24'hFF8040);
    loop_s = 1'b1;
    run(1'b0, 120, 1'b1, 24'h0);
    run(1'b0, 51, 1'b1, 24'h0);
    o = sample(1'b0);
    check("lat_s_g", 32'(o.g), 32'h05);
    check("lat_s_b", 32'(o.b), 32'h03);

    // Mid-frame reset while vga_clock is high, at (6,3).
    @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    check_reset(1'b0, "midrst");
    rst_s = 1'b0;
    run(1'b0, 40, 1'b1, 24'h0);

    // Full 640x480 timing: three lines plus up to pixel (5,3).
    check_reset(1'b1, "rst_f_c");
    loop_f = 1'b1;
    rst_f  = 1'b0;
    run(1'b1, 3 * 800 + 6, 1'b1, 24'h0);
    o = sample(1'b1);
    check("lat_f_g", 32'(o.g), 32'h05);
    check("lat_f_b", 32'(o.b), 32'h03);
    check("lat_f_ven", 32'(o.ven), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
